// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types, response codes and byte-strobe mask helper for mem_port_ctrl
package mem_port_pkg;
  typedef enum logic {CMD_RD = 1'b0, CMD_WR = 1'b1} cmd_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {ST_IDLE, ST_WDATA} state_e;
  localparam logic RESP_OK = 1'b0;
  localparam logic RESP_ERR = 1'b1;
  function automatic logic [7:0] strb_mask(input logic [1:0] size, input logic [2:0] ofs);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << ofs;
    return m[7:0];
  endfunction
endpackage

// File: rtl/mem_port_rdq.sv
// mem_port_rdq: synchronous read-data FIFO, no push-to-head bypass
module mem_port_rdq #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: core split bus to single-port RAM strobes; MEM_PORT_CTRL_ALIGN_CHK_EN enables alignment-error responses
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8,
  parameter int p_RAM_LAT = 1,
  parameter int p_RDQ_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [p_ADDR_BITS-1:0]                      mem_addr,
  input  logic                                        mem_cmd,
  input  logic [1:0]                                  mem_size,
  input  logic                                        mem_valid,
  output logic                                        mem_ready,
  output logic                                        mem_r_valid,
  input  logic                                        mem_r_ready,
  output logic [p_DATA_BITS-1:0]                      mem_r_data,
  output logic                                        mem_r_resp,
  input  logic                                        mem_w_valid,
  output logic                                        mem_w_ready,
  input  logic [p_STRB_BITS-1:0]                      mem_w_strb,
  input  logic [p_DATA_BITS-1:0]                      mem_w_data,
  output logic                                        mem_w_resp,
  output logic                                        rden,
  output logic                                        wren,
  output logic [p_ADDR_BITS-$clog2(p_STRB_BITS)-1:0]  addr,
  output logic [p_STRB_BITS-1:0]                      wrstrb,
  output logic [p_DATA_BITS-1:0]                      wrdata,
  input  logic [p_DATA_BITS-1:0]                      rddata
);
  localparam int OFS = $clog2(p_STRB_BITS);
  localparam int CW = $clog2(p_RDQ_DEPTH + 1);
  state_e state;
  logic [CW-1:0] credit;
  logic [p_ADDR_BITS-1:0] lat_addr, eff_addr;
  logic [1:0] lat_size, eff_size;
  logic [p_RAM_LAT-1:0] vld_sr, err_sr;
  logic rd_acc, wr_acc, w_fire, pop, ill, q_full, q_empty, q_err;
  logic [7:0] mask;
  logic [p_DATA_BITS:0] q_head;
  assign eff_addr = state == ST_WDATA ? lat_addr : mem_addr;
  assign eff_size = state == ST_WDATA ? lat_size : mem_size;
  assign mem_ready = state == ST_IDLE && credit < CW'(p_RDQ_DEPTH) && !q_full && !rst;
  assign rd_acc = mem_valid && mem_ready && mem_cmd == CMD_RD;
  assign wr_acc = mem_valid && mem_ready && mem_cmd == CMD_WR;
  assign mem_w_ready = (wr_acc || state == ST_WDATA) && !rst;
  assign w_fire = mem_w_valid && mem_w_ready;
  assign rden = rd_acc && !ill;
  assign wren = w_fire && !ill;
  assign addr = eff_addr[p_ADDR_BITS-1:OFS];
  assign mask = strb_mask(eff_size, 3'(eff_addr[OFS-1:0]));
  assign wrstrb = mem_w_strb & mask[p_STRB_BITS-1:0];
  assign wrdata = mem_w_data;
  assign pop = mem_r_valid && mem_r_ready;
  assign mem_r_valid = !q_empty;
  assign mem_r_data = q_head[p_DATA_BITS-1:0];
  assign mem_r_resp = q_head[p_DATA_BITS];
  assign q_err = err_sr[p_RAM_LAT-1];
`ifdef MEM_PORT_CTRL_ALIGN_CHK_EN
  logic [3:0] sb;
  assign sb = 4'd1 << eff_size;
  assign ill = ((4'(eff_addr[OFS-1:0]) & (sb - 4'd1)) != 4'd0) || (int'(sb) > p_STRB_BITS);
  always_ff @(posedge clk) mem_w_resp <= !rst && w_fire && ill;
`else
  assign ill = 1'b0;
  assign mem_w_resp = RESP_OK;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      credit <= '0;
      vld_sr <= '0;
      err_sr <= '0;
    end else begin
      state <= state == ST_IDLE ? (wr_acc && !mem_w_valid ? ST_WDATA : ST_IDLE) : (mem_w_valid ? ST_IDLE : ST_WDATA);
      if (wr_acc) begin
        lat_addr <= mem_addr;
        lat_size <= mem_size;
      end
      credit <= credit + CW'(rd_acc) - CW'(pop);
      vld_sr <= p_RAM_LAT'({vld_sr, rd_acc});
      err_sr <= p_RAM_LAT'({err_sr, rd_acc && ill});
    end
  mem_port_rdq #(.WIDTH(p_DATA_BITS + 1), .DEPTH(p_RDQ_DEPTH)) u_rdq (
    .clk(clk),
    .rst(rst),
    .push(vld_sr[p_RAM_LAT-1]),
    .pop(pop),
    .din({q_err, rddata & {p_DATA_BITS{!q_err}}}),
    .full(q_full),
    .empty(q_empty),
    .head(q_head)
  );
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed self-checking bench for mem_port_ctrl with a 2-cycle RAM model
module tb_mem_port_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic mem_cmd = 1'b0;
  logic [1:0] mem_size = 2'd2;
  logic mem_valid = 1'b0;
  logic mem_ready;
  logic mem_r_valid;
  logic mem_r_ready = 1'b0;
  logic [31:0] mem_r_data;
  logic mem_r_resp;
  logic mem_w_valid = 1'b0;
  logic mem_w_ready;
  logic [3:0] mem_w_strb = 4'hF;
  logic [31:0] mem_w_data = '0;
  logic mem_w_resp;
  logic rden, wren;
  logic [29:0] addr;
  logic [3:0] wrstrb;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic [31:0] ram [64];
  logic [31:0] p1;
  logic init_ram = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mem_port_ctrl #(.p_RAM_LAT(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_r_valid(mem_r_valid),
    .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_strb(mem_w_strb),
    .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp), .rden(rden), .wren(wren),
    .addr(addr), .wrstrb(wrstrb), .wrdata(wrdata), .rddata(rddata)
  );
  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction
  always @(posedge clk) begin
    if (init_ram) for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
    else if (wren) for (int b = 0; b < 4; b++) if (wrstrb[b]) ram[addr[5:0]][8*b+:8] <= wrdata[8*b+:8];
    if (rden) p1 <= ram[addr[5:0]];
    rddata <= p1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    int idx, rx, cnt, cnt2;
    repeat (3) step();
    #1;
    check("rst_ready", mem_ready, 0);
    check("rst_rvalid", mem_r_valid, 0);
    check("rst_rden_wren", {rden, wren}, 0);
    check("rst_wresp", mem_w_resp, 0);
    init_ram = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rel_ready", mem_ready, 1);
    // single read, latency 2
    step();
    mem_valid = 1; mem_cmd = 0; mem_size = 2; mem_addr = 32'h10; mem_r_ready = 1;
    #1;
    check("rd_rden", rden, 1);
    check("rd_addr", addr, 30'h4);
    step();
    mem_valid = 0;
    #1 check("rd_t1_valid", mem_r_valid, 0);
    step();
    #1 check("rd_t2_valid", mem_r_valid, 0);
    step();
    #1;
    check("rd_t3_valid", mem_r_valid, 1);
    check("rd_t3_data", mem_r_data, 32'hC0DE_0004);
    check("rd_t3_resp", mem_r_resp, 0);
    step();
    #1 check("rd_t4_valid", mem_r_valid, 0);
    // backpressure: six reads, queue holds four
    mem_r_ready = 0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      mem_valid = idx < 6; mem_cmd = 0; mem_size = 2; mem_addr = 32'(idx * 4);
      #1 if (mem_valid && mem_ready) idx++;
    end
    check("bp_accepted", idx, 4);
    check("bp_ready_low", mem_ready, 0);
    rx = 0;
    for (int c = 0; c < 30 && rx < 6; c++) begin
      step();
      mem_r_ready = 1;
      mem_valid = idx < 6; mem_addr = 32'(idx * 4);
      #1;
      if (mem_valid && mem_ready) idx++;
      if (mem_r_valid && mem_r_ready) begin
        check("bp_data", mem_r_data, 64'(init_val(rx)));
        rx++;
      end
    end
    check("bp_total_acc", idx, 6);
    check("bp_total_rx", rx, 6);
    // write with data one cycle after accept
    step();
    mem_valid = 1; mem_cmd = 1; mem_size = 0; mem_addr = 32'h22;
    mem_w_valid = 0; mem_w_strb = 4'hF; mem_w_data = 32'hAABB_CCDD;
    #1;
    check("wd_wready", mem_w_ready, 1);
    check("wd_nowren", wren, 0);
    step();
    mem_valid = 0; mem_addr = 32'h0; mem_w_valid = 1;
    #1;
    check("wd_wren", wren, 1);
    check("wd_strb", wrstrb, 4'h4);
    check("wd_addr", addr, 30'h8);
    check("wd_ready_low", mem_ready, 0);
    step();
    mem_w_valid = 0;
    #1;
    check("wd_idle_ready", mem_ready, 1);
    check("wd_ram", ram[8], 32'hC0BB_0008);
    // halfword at offset 2 masks upper bytes
    step();
    mem_valid = 1; mem_cmd = 1; mem_size = 1; mem_addr = 32'h6; mem_w_valid = 1; mem_w_data = 32'h1234_5678;
    #1 check("hw_strb", wrstrb, 4'hC);
    step();
    mem_valid = 0; mem_w_valid = 0;
    #1 check("hw_ram", ram[1], 32'h1234_0001);
    // back-to-back writes with data in the accept cycle
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      mem_valid = 1; mem_cmd = 1; mem_size = 2; mem_addr = 32'h40 + 32'(4 * i);
      mem_w_valid = 1; mem_w_data = 32'h1111_0000 + 32'(i);
      #1;
      if (wren) cnt++;
      if (mem_ready) cnt2++;
    end
    step();
    mem_valid = 0; mem_w_valid = 0;
    #1;
    check("b2b_wren", cnt, 8);
    check("b2b_ready", cnt2, 8);
    check("b2b_first", ram[16], 32'h1111_0000);
    check("b2b_last", ram[23], 32'h1111_0007);
`ifdef MEM_PORT_CTRL_ALIGN_CHK_EN
    step();
    mem_valid = 1; mem_cmd = 0; mem_size = 2; mem_addr = 32'h2; mem_r_ready = 1;
    #1;
    check("al_rd_nordn", rden, 0);
    check("al_rd_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    step();
    step();
    #1;
    check("al_rd_valid", mem_r_valid, 1);
    check("al_rd_resp", mem_r_resp, 1);
    check("al_rd_data", mem_r_data, 0);
    step();
    mem_valid = 1; mem_cmd = 1; mem_size = 1; mem_addr = 32'h1; mem_w_valid = 1;
    #1;
    check("al_wr_nowren", wren, 0);
    check("al_wr_wready", mem_w_ready, 1);
    check("al_wr_resp0", mem_w_resp, 0);
    step();
    mem_valid = 0; mem_w_valid = 0;
    #1 check("al_wr_resp1", mem_w_resp, 1);
    step();
    #1 check("al_wr_resp2", mem_w_resp, 0);
`else
    step();
    mem_valid = 1; mem_cmd = 1; mem_size = 1; mem_addr = 32'h1; mem_w_valid = 1;
    #1;
    check("ua_wr_wren", wren, 1);
    check("ua_wr_strb", wrstrb, 4'h6);
    step();
    mem_valid = 0; mem_w_valid = 0;
    #1 check("ua_wr_resp", mem_w_resp, 0);
`endif
    // reset with reads in flight
    mem_r_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_valid = 1; mem_cmd = 0; mem_size = 2; mem_addr = 32'(4 * i);
    end
    step();
    mem_valid = 0; rst = 1;
    step();
    rst = 0;
    #1 check("rst2_ready", mem_ready, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      #1 if (mem_r_valid) cnt++;
    end
    check("rst2_novalid", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      mem_valid = 1; mem_cmd = 0; mem_addr = 32'(4 * i);
      #1 if (mem_ready) cnt++;
    end
    check("rst2_credit", cnt, 4);
    step();
    mem_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
